// File: rtl/mem_stage_bus_pkg.sv
// Shared types and encodings for the bus-based MEM stage: FSM states,
// one-hot load/store selects, trap causes and lane helpers.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    // Store select, one-hot {sw,sh,sb}
    localparam logic [2:0] SC_SW = 3'b100;
    localparam logic [2:0] SC_SH = 3'b010;
    localparam logic [2:0] SC_SB = 3'b001;

    // Load select, one-hot {lhu,lbu,lw,lh,lb}
    localparam logic [4:0] LC_LHU = 5'b10000;
    localparam logic [4:0] LC_LBU = 5'b01000;
    localparam logic [4:0] LC_LW  = 5'b00100;
    localparam logic [4:0] LC_LH  = 5'b00010;
    localparam logic [4:0] LC_LB  = 5'b00001;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    // Byte lanes touched by the access; loads use the same lane pattern as stores.
    function automatic logic [3:0] lane_be(input logic [2:0] st, input logic [4:0] ld,
                                           input logic [1:0] off);
        logic [3:0] be;
        if (st == SC_SW || ld == LC_LW)
            be = 4'b1111;
        else if (st == SC_SH || ld == LC_LH || ld == LC_LHU)
            be = off[1] ? 4'b1100 : 4'b0011;
        else
            be = 4'b0001 << off;
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] st, input logic [31:0] data);
        logic [31:0] wd;
        case (st)
            SC_SB:   wd = {4{data[7:0]}};
            SC_SH:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_stage_bus_align.sv
// Load data aligner: rotates the bus word so the addressed byte/half lands
// in the low lanes, then sign- or zero-extends according to the load type.
module load_align_ext
    import mem_bus_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [4:0]  loadcntrl,
    output logic [31:0] memres
);

    logic [31:0] w_rot;

    always_comb begin
        case (offset)
            2'd1:    w_rot = {rdata[7:0],  rdata[31:8]};
            2'd2:    w_rot = {rdata[15:0], rdata[31:16]};
            2'd3:    w_rot = {rdata[23:0], rdata[31:24]};
            default: w_rot = rdata;
        endcase
    end

    always_comb begin
        case (loadcntrl)
            LC_LB:   memres = {{24{w_rot[7]}}, w_rot[7:0]};
            LC_LBU:  memres = {24'd0, w_rot[7:0]};
            LC_LH:   memres = {{16{w_rot[15]}}, w_rot[15:0]};
            LC_LHU:  memres = {16'd0, w_rot[15:0]};
            LC_LW:   memres = w_rot;
            default: memres = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_bus.sv
// MEM pipeline stage driving a req/gnt/rvalid data bus; stalls upstream while
// a transfer is in flight, traps misaligned/timed-out accesses, parks results under debug.
module mem_stage_bus
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              debug,
    input  logic              ex_valid,
    input  logic [2:0]        EX_MEM_storecntrl,
    input  logic [4:0]        EX_MEM_loadcntrl,
    input  logic [31:0]       EX_MEM_alures,
    input  logic [31:0]       EX_MEM_alusec,
    input  logic [4:0]        EX_MEM_rd,
    input  logic              EX_MEM_regwrite,
    input  logic              EX_MEM_memread,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic              MEM_WB_valid,
    output logic              MEM_WB_regwrite,
    output logic              MEM_WB_memread,
    output logic [4:0]        MEM_WB_rd,
    output logic [31:0]       MEM_WB_alures,
    output logic [31:0]       MEM_WB_memres,
    output logic              MEM_WB_trap,
    output logic [3:0]        MEM_WB_cause
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_e            r_state;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_off;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic [4:0]        r_load;
    logic [4:0]        r_rd;
    logic              r_regwrite;
    logic              r_memread;
    logic [31:0]       r_alures;
    logic [31:0]       r_hold_rdata;
    logic              r_hold_trap;

    logic        w_is_st, w_is_ld, w_misal, w_accept, w_acc_mem;
    logic        w_busy, w_tmo, w_done_ok, w_xfer_done, w_deliver;
    logic        w_res_trap;
    logic [3:0]  w_fault_cause;
    logic [31:0] w_align_in, w_memres;

    always_comb begin
        w_is_st   = |EX_MEM_storecntrl;
        w_is_ld   = |EX_MEM_loadcntrl;
        w_misal   = ((EX_MEM_storecntrl == SC_SH || EX_MEM_loadcntrl == LC_LH ||
                      EX_MEM_loadcntrl == LC_LHU) && EX_MEM_alures[0]) ||
                    ((EX_MEM_storecntrl == SC_SW || EX_MEM_loadcntrl == LC_LW) &&
                      (EX_MEM_alures[1:0] != 2'b00));
        w_accept  = (r_state == ST_IDLE) && ex_valid && !debug;
        w_acc_mem = w_accept && (w_is_st || w_is_ld) && !w_misal;

        // Timeout wins over a same-cycle gnt/rvalid so the bus request can drop cleanly.
        w_busy      = (r_state == ST_REQ) || (r_state == ST_WAIT);
        w_tmo       = w_busy && (r_cnt == TMO_LAST);
        w_done_ok   = !w_tmo && (((r_state == ST_REQ) && r_we && mem_gnt) ||
                                 ((r_state == ST_WAIT) && mem_rvalid));
        w_xfer_done = w_tmo || w_done_ok;
        w_deliver   = ((w_busy && w_xfer_done) || (r_state == ST_HOLD)) && !debug;

        stall = w_acc_mem || ((r_state != ST_IDLE) && !w_deliver);

        w_res_trap    = (r_state == ST_HOLD) ? r_hold_trap : w_tmo;
        w_fault_cause = r_we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
        w_align_in    = (r_state == ST_HOLD) ? r_hold_rdata : mem_rdata;

        mem_req   = (r_state == ST_REQ) && !w_tmo;
        mem_we    = mem_req && r_we;
        mem_be    = mem_req ? r_be : '0;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
    end

    load_align_ext u_align (
        .rdata     (w_align_in),
        .offset    (r_off),
        .loadcntrl (r_load),
        .memres    (w_memres)
    );

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_off        <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_load       <= '0;
            r_rd         <= '0;
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_alures     <= '0;
            r_hold_rdata <= '0;
            r_hold_trap  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc_mem) begin
                        r_state    <= ST_REQ;
                        r_cnt      <= '0;
                        r_addr     <= {EX_MEM_alures[ADDR_W-1:2], 2'b00};
                        r_off      <= EX_MEM_alures[1:0];
                        r_be       <= lane_be(EX_MEM_storecntrl, EX_MEM_loadcntrl,
                                              EX_MEM_alures[1:0]);
                        r_wdata    <= lane_wdata(EX_MEM_storecntrl, EX_MEM_alusec);
                        r_we       <= w_is_st;
                        r_load     <= EX_MEM_loadcntrl;
                        r_rd       <= EX_MEM_rd;
                        r_regwrite <= EX_MEM_regwrite;
                        r_memread  <= EX_MEM_memread;
                        r_alures   <= EX_MEM_alures;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_xfer_done) begin
                        if (debug) begin
                            r_state      <= ST_HOLD;
                            r_hold_rdata <= mem_rdata;
                            r_hold_trap  <= w_tmo;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (r_state == ST_REQ && mem_gnt && !r_we) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!debug)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            MEM_WB_valid    <= 1'b0;
            MEM_WB_regwrite <= 1'b0;
            MEM_WB_memread  <= 1'b0;
            MEM_WB_rd       <= '0;
            MEM_WB_alures   <= '0;
            MEM_WB_memres   <= '0;
            MEM_WB_trap     <= 1'b0;
            MEM_WB_cause    <= '0;
        end else if (w_deliver) begin
            MEM_WB_valid    <= 1'b1;
            MEM_WB_regwrite <= r_regwrite && !w_res_trap;
            MEM_WB_memread  <= r_memread;
            MEM_WB_rd       <= r_rd;
            MEM_WB_alures   <= r_alures;
            MEM_WB_memres   <= w_res_trap ? '0 : w_memres;
            MEM_WB_trap     <= w_res_trap;
            MEM_WB_cause    <= w_res_trap ? w_fault_cause : '0;
        end else if (w_accept && !w_acc_mem) begin
            MEM_WB_valid    <= 1'b1;
            MEM_WB_regwrite <= EX_MEM_regwrite && !w_misal;
            MEM_WB_memread  <= EX_MEM_memread;
            MEM_WB_rd       <= EX_MEM_rd;
            MEM_WB_alures   <= EX_MEM_alures;
            MEM_WB_memres   <= '0;
            MEM_WB_trap     <= w_misal;
            MEM_WB_cause    <= w_misal ? (w_is_st ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN) : '0;
        end else if (!debug) begin
            // Bubble; with debug=1 the register is frozen instead.
            MEM_WB_valid    <= 1'b0;
            MEM_WB_regwrite <= 1'b0;
            MEM_WB_trap     <= 1'b0;
        end
    end

endmodule
